// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for a single data memory.
// Each transaction takes three cycles: IDLE (arbitrate and latch), ACCESS
// (drive memory), RESP (acknowledge the winner).
// Optional bus lock: define MEM_ARB_LOCK_EN to add m0_lock/m1_lock and the
// lock-owner logic. When it is undefined, arbitration is pure round-robin.
//
// Handshake (req/ack): a requester raises mX_req with we/addr/wdata valid.
// It holds them stable until mX_ack, which is a single-cycle pulse. Read
// data on mX_rdata is valid while mX_ack is high. A req still high in the
// IDLE cycle after ack is treated as a new request.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   output logic              m0_ack,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              ptr_q;        // id of the requester granted last
   logic              win_q;        // id of the current transaction's winner
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;      // shared read-data register
   logic              grant_valid;
   logic              grant_id;

`ifdef MEM_ARB_LOCK_EN
   logic              lock_q;       // lock bit latched with the grant
   logic              owner_valid_q;
   logic              owner_q;
`endif

   // Arbitration: a lock owner excludes the other side; otherwise round-robin on ties
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      if (owner_valid_q) begin
         grant_valid = owner_q ? m1_req : m0_req;
         grant_id    = owner_q;
      end else begin
`else
      begin
`endif
         if (m0_req && m1_req) begin
            grant_valid = 1'b1;
            grant_id    = ~ptr_q;
         end else if (m0_req) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end else if (m1_req) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
      end
   end

   // Next-state logic: IDLE waits for a grant, then ACCESS and RESP each last one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (grant_valid) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs: memory is driven only in ACCESS, and the winner's ack only in RESP
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      case (state_q)
         S_ACCESS: begin
            mem_read  = ~we_q;
            mem_write = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
         end
         S_RESP: begin
            m0_ack = ~win_q;
            m1_ack = win_q;
         end
         default: ;
      endcase
   end

   assign m0_rdata  = rdata_q;
   assign m1_rdata  = rdata_q;
   assign dbg_state = state_q;

   // State register; a reset at any point abandons the in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Latch the winner's request so later input changes cannot disturb it
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MEM_ARB_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else if (state_q == S_IDLE && grant_valid) begin
         win_q   <= grant_id;
         we_q    <= grant_id ? m1_we    : m0_we;
         addr_q  <= grant_id ? m1_addr  : m0_addr;
         wdata_q <= grant_id ? m1_wdata : m0_wdata;
`ifdef MEM_ARB_LOCK_EN
         lock_q  <= grant_id ? m1_lock  : m0_lock;
`endif
      end
   end

   // Read data is captured at the end of ACCESS; writes leave it untouched
   always_ff @(posedge clk) begin
      if (rst)                              rdata_q <= '0;
      else if (state_q == S_ACCESS && !we_q) rdata_q <= mem_rdata;
   end

   // Round-robin pointer and lock ownership advance when a transaction completes
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q         <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
         owner_valid_q <= 1'b0;
         owner_q       <= 1'b0;
`endif
      end else if (state_q == S_RESP) begin
`ifdef MEM_ARB_LOCK_EN
         if (!owner_valid_q) ptr_q <= win_q;
         owner_valid_q <= lock_q;
         owner_q       <= win_q;
`else
         ptr_q <= win_q;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with hand-computed
// expectations, a grant-order scoreboard and continuous exclusivity checks.
// The lock-order test follows MEM_ARB_LOCK_EN when that macro is defined.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
`ifdef MEM_ARB_LOCK_EN
   logic        m0_lock, m1_lock;
`endif
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [0:0]  exp_q[$];   // expected winner id of each upcoming ack

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
`ifdef MEM_ARB_LOCK_EN
      .m0_lock   (m0_lock),
      .m1_lock   (m1_lock),
`endif
      .m0_ack    (m0_ack),
      .m1_ack    (m1_ack),
      .m0_rdata  (m0_rdata),
      .m1_rdata  (m1_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
      m0_lock = 1'b0; m1_lock = 1'b0;
`endif
      mem_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   // Scoreboard plus exclusivity checks, sampled on the falling edge
   always @(negedge clk) begin
      check_eq("ack_excl", {63'd0, m0_ack & m1_ack}, 64'd0);
      check_eq("rw_excl", {63'd0, mem_read & mem_write}, 64'd0);
      if (m0_ack || m1_ack) begin
         check_eq("sb_pending", {63'd0, exp_q.size() > 0}, 64'd1);
         if (exp_q.size() > 0) check_eq("sb_grant", {63'd0, m1_ack}, {63'd0, exp_q.pop_front()});
      end
   end

   initial begin
      do_reset();
      // reset state
      check_eq("rst_m0_ack", m0_ack, 0);
      check_eq("rst_m1_ack", m1_ack, 0);
      check_eq("rst_mem_read", mem_read, 0);
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_rdata", m0_rdata, 0);

      // m0 read at 0x10; req is dropped after the grant and the ack still comes
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
      exp_q.push_back(1'b0);
      step();
      check_eq("rd_mem_read", mem_read, 1);
      check_eq("rd_mem_write", mem_write, 0);
      check_eq("rd_mem_addr", mem_addr, 32'h10);
      check_eq("rd_early_ack", m0_ack, 0);
      m0_req = 1'b0; m0_addr = 32'hFFFF;
      step();
      check_eq("rd_m0_ack", m0_ack, 1);
      check_eq("rd_m1_ack", m1_ack, 0);
      check_eq("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
      check_eq("rd_resp_mem_read", mem_read, 0);
      mem_rdata = 32'h0;
      step();
      check_eq("rd_ack_done", m0_ack, 0);
      check_eq("rd_hold_m0", m0_rdata, 32'hDEADBEEF);
      check_eq("rd_hold_m1", m1_rdata, 32'hDEADBEEF);

      // m1 write 0x20 <- 0x12345678; mem_write is high for exactly one cycle
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
      mem_rdata = 32'hAAAA5555;
      exp_q.push_back(1'b1);
      check_eq("wr_idle_write", mem_write, 0);
      step();
      check_eq("wr_mem_write", mem_write, 1);
      check_eq("wr_mem_read", mem_read, 0);
      check_eq("wr_mem_addr", mem_addr, 32'h20);
      check_eq("wr_mem_wdata", mem_wdata, 32'h12345678);
      check_eq("wr_m0_ack_a", m0_ack, 0);
      step();
      check_eq("wr_m1_ack", m1_ack, 1);
      check_eq("wr_m0_ack_b", m0_ack, 0);
      check_eq("wr_resp_write", mem_write, 0);
      check_eq("wr_rdata_kept", m1_rdata, 32'hDEADBEEF);
      m1_req = 1'b0;
      step();
      check_eq("wr_m1_ack_done", m1_ack, 0);

      // reset during the ACCESS cycle of an m0 read aborts it
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30; mem_rdata = 32'h11112222;
      step();
      check_eq("ab_mem_read", mem_read, 1);
      rst = 1'b1; m0_req = 1'b0;
      step();
      rst = 1'b0;
      check_eq("ab_m0_ack", m0_ack, 0);
      check_eq("ab_m1_ack", m1_ack, 0);
      check_eq("ab_mem_read_off", mem_read, 0);
      check_eq("ab_mem_write_off", mem_write, 0);
      check_eq("ab_mem_addr", mem_addr, 0);
      check_eq("ab_rdata_clr", m0_rdata, 0);
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h55;
      exp_q.push_back(1'b1);
      step();
      check_eq("ab_m1_write", mem_write, 1);
      check_eq("ab_m1_addr", mem_addr, 32'h44);
      check_eq("ab_m1_wdata", mem_wdata, 32'h55);
      step();
      check_eq("ab_m1_ack", m1_ack, 1);
      check_eq("ab_no_m0_ack", m0_ack, 0);
      m1_req = 1'b0;
      step();

      // both requesters held high: grants m0,m1,m0,m1 with acks at 2,5,8,11
      do_reset();
      m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200;
      mem_rdata = 32'hCAFEF00D;
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      check_eq("rr_c0_ack", {m0_ack, m1_ack}, 0);
      for (int c = 1; c <= 12; c++) begin
         step();
         check_eq("rr_m0_ack", m0_ack, (c == 2 || c == 8) ? 1 : 0);
         check_eq("rr_m1_ack", m1_ack, (c == 5 || c == 11) ? 1 : 0);
         if (c == 1) check_eq("rr_addr_m0", mem_addr, 32'h100);
         if (c == 4) check_eq("rr_addr_m1", mem_addr, 32'h200);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      step();

      // lock ordering: m0 reads with lock=1 then lock=0, m1 requesting throughout
      do_reset();
      m0_req = 1'b1; m1_req = 1'b1;
`ifdef MEM_ARB_LOCK_EN
      m0_lock = 1'b1;
      exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
      exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`endif
      for (int c = 1; c <= 8; c++) begin
         step();
`ifdef MEM_ARB_LOCK_EN
         if (c == 2) m0_lock = 1'b0;
         check_eq("lk_m0_ack", m0_ack, (c == 2 || c == 5) ? 1 : 0);
         check_eq("lk_m1_ack", m1_ack, (c == 8) ? 1 : 0);
`else
         check_eq("lk_m0_ack", m0_ack, (c == 2 || c == 8) ? 1 : 0);
         check_eq("lk_m1_ack", m1_ack, (c == 5) ? 1 : 0);
`endif
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      step();
      step();

      check_eq("sb_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request and memory address width.
REQ-002 Parameter DATA_W, default 32, read/write data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_req / m1_req  input  1  requester 0/1 transaction request.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  ADDR_W  byte address, passed unmodified to memory.
REQ-008 m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-009 m0_ack / m1_ack  output  1  one-cycle transaction-complete pulse.
REQ-010 m0_rdata / m1_rdata  output  DATA_W  read data, valid while matching ack is high.
REQ-011 mem_read, mem_write  output  1  data-memory read/write enables.
REQ-012 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W (combinational memory read).
REQ-013 m0_lock / m1_lock  input  1  bus-lock request; present only under MEM_ARB_LOCK_EN.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; IDLE -> ACCESS when any req sampled high; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-015 In IDLE, one req high: grant it; both high: grant requester not granted last (round-robin pointer; pointer = 1 after reset, so m0 wins first tie).
REQ-016 On IDLE -> ACCESS, latch winner id, we, addr, wdata; later input changes have no effect on that transaction.
REQ-017 In ACCESS only: mem_addr/mem_wdata = latched values, mem_write = we, mem_read = ~we; all mem_* outputs 0 in IDLE and RESP.
REQ-018 At end of ACCESS, capture mem_rdata into shared rdata register for reads; writes leave rdata register unchanged.
REQ-019 In RESP, assert ack of latched winner only; acks are never high simultaneously; update pointer to winner.
REQ-020 m0_rdata and m1_rdata both drive the rdata register; value holds between transactions.
REQ-021 Latency: req high in IDLE cycle N -> mem access cycle N+1 -> ack cycle N+2; max throughput one transaction per 3 cycles.
REQ-022 Requester holds req and fields stable until ack; req still high in the IDLE cycle after ack is a new request.
REQ-023 Non-granted requester's req is ignored (no ack, no side effect) until sampled in a later IDLE.
REQ-024 req deasserted after being latched does not cancel the transaction; ack still issued.

Reset
REQ-025 rst high at a clock edge: state = IDLE, pointer = 1, rdata register = 0, lock owner cleared; outputs all 0 in following cycle.
REQ-026 rst during ACCESS or RESP aborts: no ack issued; a write in ACCESS at the reset edge is already committed, no further mem_write.

Configuration
REQ-027 Macro MEM_ARB_LOCK_EN defined: mX_lock ports exist, latched with the grant; completed transaction with lock = 1 makes that requester lock owner.
REQ-028 While a lock owner exists, IDLE grants only the owner; other req ignored; owner's next completed transaction with lock = 0 clears ownership; pointer not updated while locked.
REQ-029 MEM_ARB_LOCK_EN undefined: no lock ports or lock state; pure round-robin per REQ-015.

Verification
REQ-030 m0 read only, addr 0x10, mem_rdata 0xDEADBEEF in ACCESS -> mem_read=1 in cycle N+1, m0_ack + m0_rdata=0xDEADBEEF cycle N+2.
REQ-031 m1 write addr 0x20 data 0x12345678 -> mem_write=1, mem_addr=0x20 exactly one cycle; m1_ack cycle N+2; m0_ack stays 0.
REQ-032 Both req held high continuously after reset -> grants m0, m1, m0, m1 with acks at cycles 2, 5, 8, 11.
REQ-033 rst asserted during ACCESS of m0 read -> no m0_ack; next cycle all outputs 0; subsequent m1 request served normally.
REQ-034 MEM_ARB_LOCK_EN: m0 two reads lock=1 then lock=0 with m1 req constant -> m0, m0, m1 order; without macro -> m0, m1, m0.
REQ-035 All tests: assert m0_ack & m1_ack never both 1, and mem_read & mem_write never both 1.
